mem_arbiter: RTL and testbench

Sequencing arbiter between the CPU core's instruction-fetch and data (load/store) SRAM-like ports and the single `mem_*` port of `axi_interface`. It holds one outstanding transaction at a time and latches the winning request for its full duration. It routes `mem_ready` and `mem_data` back to the owner and produces the fetch/memory stall requests for the hazard unit. It replaces the ad-hoc `inst_miss` select logic in `mycpu_top`.

---
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and load/store ports onto one memory port, one outstanding access, request held for the grant.
// Grant 1 cycle after request; `ARB_ROUND_ROBIN_EN selects round-robin tie-break, otherwise data wins ties.
module mem_arbiter #(
  parameter logic [15:0] CONFREG_HI  = 16'hbfaf,
  parameter logic [15:0] CONFREG_MAP = 16'h1faf
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic [3:0]  d_sel,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  input  logic        flush,
  output logic [31:0] mem_a,
  output logic        mem_access,
  output logic        mem_write,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_st_data,
  output logic        mem_flush,
  input  logic        mem_ready,
  input  logic [31:0] mem_data,
  output logic        stallreq_if,
  output logic        stallreq_mem
);

  typedef enum logic [1:0] {IDLE, INST, DATA} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [3:0]  sel_q, sel_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic        last_d_q, last_d_d;

  logic        d_cand, i_cand, grant_d, grant_i, busy;
  logic [31:0] d_addr_map;

  assign d_addr_map = (d_addr[31:16] == CONFREG_HI) ? {CONFREG_MAP, d_addr[15:0]} : d_addr;
  // A flushed M-stage access must never reach the bus.
  assign d_cand = d_req & ~flush;
  assign i_cand = i_req;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    sel_d    = sel_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    last_d_d = last_d_q;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_cand && i_cand) begin
`ifdef ARB_ROUND_ROBIN_EN
          grant_i = last_d_q;
          grant_d = ~last_d_q;
`else
          grant_d = 1'b1;
`endif
        end else begin
          grant_i = i_cand;
          grant_d = d_cand;
        end
      end
      INST: begin
        if (mem_ready) begin
          if (d_cand) grant_d = 1'b1;
          else        state_d = IDLE;
        end
      end
      DATA: begin
        if (flush) begin
          state_d = IDLE;
        end else if (mem_ready) begin
          if (i_cand) grant_i = 1'b1;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant_d) begin
      state_d  = DATA;
      addr_d   = d_addr_map;
      size_d   = d_size;
      sel_d    = d_sel;
      write_d  = d_write;
      wdata_d  = d_wdata;
      last_d_d = 1'b1;
    end else if (grant_i) begin
      state_d  = INST;
      addr_d   = i_addr;
      size_d   = 2'b10;
      sel_d    = 4'b1111;
      write_d  = 1'b0;
      wdata_d  = 32'h0;
      last_d_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      addr_q   <= 32'h0;
      size_q   <= 2'b00;
      sel_q    <= 4'b0000;
      write_q  <= 1'b0;
      wdata_q  <= 32'h0;
      last_d_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      sel_q    <= sel_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      last_d_q <= last_d_d;
    end
  end

  // Holding registers keep the previous grant in IDLE, so the bus is gated by state.
  assign busy        = (state_q != IDLE);
  assign mem_access  = busy;
  assign mem_a       = busy ? addr_q  : 32'h0;
  assign mem_write   = busy & write_q;
  assign mem_size    = busy ? size_q  : 2'b00;
  assign mem_sel     = busy ? sel_q   : 4'b0000;
  assign mem_st_data = busy ? wdata_q : 32'h0;
  assign mem_flush   = (state_q == DATA) & flush;

  assign i_ready      = (state_q == INST) & mem_ready;
  assign d_ready      = (state_q == DATA) & mem_ready & ~flush;
  assign i_rdata      = i_ready ? mem_data : 32'h0;
  assign d_rdata      = d_ready ? mem_data : 32'h0;
  assign stallreq_if  = i_req & ~i_ready;
  assign stallreq_mem = d_req & ~d_ready & ~flush;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table for data-path latching plus hand sequences, ready pulses checked by a scoreboard.
module tb_mem_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        i_req, i_ready, d_req, d_write, d_ready, flush;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic [1:0]  d_size, mem_size;
  logic [3:0]  d_sel, mem_sel;
  logic [31:0] mem_a, mem_st_data, mem_data;
  logic        mem_access, mem_write, mem_flush, mem_ready;
  logic        stallreq_if, stallreq_mem;

  always #5 aclk = ~aclk;

  mem_arbiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_sel(d_sel),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
    .flush(flush), .mem_a(mem_a), .mem_access(mem_access), .mem_write(mem_write),
    .mem_size(mem_size), .mem_sel(mem_sel), .mem_st_data(mem_st_data),
    .mem_flush(mem_flush), .mem_ready(mem_ready), .mem_data(mem_data),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
  );

  typedef struct {
    logic        is_d;
    logic [31:0] data;
  } sb_t;

  typedef struct {
    logic        write;
    logic [1:0]  size;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_a;
  } vec_t;

  sb_t  sb_q[$];
  sb_t  mon_e;
  vec_t vecs[6];
  int   n_total = 0;
  int   n_pass = 0;
  logic first_d, exp_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic smp();
    @(negedge aclk);
  endtask

  task automatic push(input logic is_d, input logic [31:0] data);
    sb_t e;
    e.is_d = is_d;
    e.data = data;
    sb_q.push_back(e);
    mem_ready = 1'b1;
    mem_data  = data;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    i_req = 0; d_req = 0; flush = 0; mem_ready = 0; mem_data = 0;
    cyc();
    cyc();
    aresetn = 1'b1;
  endtask

  // Every ready pulse must match the oldest outstanding expectation.
  always @(negedge aclk) begin
    if (i_ready || d_ready) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_ready: i_ready=%b d_ready=%b, nothing outstanding", i_ready, d_ready);
      end else begin
        mon_e = sb_q.pop_front();
        chk("ready_owner", 32'(d_ready), 32'(mon_e.is_d));
        chk("rdata", d_ready ? d_rdata : i_rdata, mon_e.data);
      end
    end
    if (!i_ready) chk("i_rdata_zero", i_rdata, 32'h0);
    if (!d_ready) chk("d_rdata_zero", d_rdata, 32'h0);
  end

  initial begin
    vecs[0] = '{1'b1, 2'b01, 4'b0011, 32'hbfaf8000, 32'h1234abcd, 32'h1faf8000};
    vecs[1] = '{1'b0, 2'b10, 4'b1111, 32'h1faf0000, 32'h00000000, 32'h1faf0000};
    vecs[2] = '{1'b1, 2'b00, 4'b1000, 32'hbfaf0004, 32'hcafe0042, 32'h1faf0004};
    vecs[3] = '{1'b0, 2'b10, 4'b1111, 32'hbfae0010, 32'h00000011, 32'hbfae0010};
    vecs[4] = '{1'b1, 2'b01, 4'b1100, 32'h0000fffc, 32'hbeef0000, 32'h0000fffc};
    vecs[5] = '{1'b0, 2'b10, 4'b1111, 32'hbfafff00, 32'h00000022, 32'h1fafff00};

    i_req = 0; i_addr = 0; d_req = 0; d_write = 0; d_size = 0; d_sel = 0;
    d_addr = 0; d_wdata = 0; flush = 0; mem_ready = 0; mem_data = 0;
    cyc();
    smp();
    chk("rst_access", 32'(mem_access), 32'h0);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_write", 32'(mem_write), 32'h0);
    chk("rst_size", 32'(mem_size), 32'h0);
    chk("rst_sel", 32'(mem_sel), 32'h0);
    chk("rst_st_data", mem_st_data, 32'h0);
    chk("rst_flush", 32'(mem_flush), 32'h0);
    chk("rst_readies", 32'({i_ready, d_ready}), 32'h0);
    cyc();
    aresetn = 1'b1;

    // Single fetch, downstream answers 3 cycles after the grant.
    cyc();
    i_req = 1; i_addr = 32'hbfc00000;
    smp();
    chk("f_access_req_cycle", 32'(mem_access), 32'h0);
    chk("f_stall_before", 32'(stallreq_if), 32'h1);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      smp();
      chk("f_access_held", 32'(mem_access), 32'h1);
      chk("f_mem_a", mem_a, 32'hbfc00000);
      chk("f_attrs", {mem_write, mem_size, mem_sel}, {25'h0, 1'b0, 2'b10, 4'b1111});
      chk("f_stall_wait", 32'(stallreq_if), 32'h1);
    end
    cyc();
    push(1'b0, 32'h0badf00d);
    smp();
    chk("f_access_ready_cycle", 32'(mem_access), 32'h1);
    chk("f_i_ready", 32'(i_ready), 32'h1);
    chk("f_stall_drop", 32'(stallreq_if), 32'h0);
    cyc();
    mem_ready = 0; i_req = 0;
    smp();
    chk("f_back_idle", 32'(mem_access), 32'h0);

    // Simultaneous requests, two rounds, handover without an idle bubble.
    do_reset();
`ifdef ARB_ROUND_ROBIN_EN
    first_d = 1'b0;
`else
    first_d = 1'b1;
`endif
    for (int r = 0; r < 2; r++) begin
      cyc();
      i_req = 1; i_addr = 32'hbfc00100 + 32'(r * 4);
      d_req = 1; d_write = 0; d_size = 2'b10; d_sel = 4'b1111;
      d_addr = 32'h1faf0000 + 32'(r * 8); d_wdata = 0;
      smp();
      chk("tie_no_grant_yet", 32'(mem_access), 32'h0);
      for (int g = 0; g < 2; g++) begin
        cyc();
        mem_ready = 0;
        if (g == 1) begin
          if (first_d) d_req = 0;
          else         i_req = 0;
        end
        exp_d = (g == 0) ? first_d : ~first_d;
        smp();
        chk("tie_access", 32'(mem_access), 32'h1);
        chk("tie_owner_addr", mem_a, exp_d ? d_addr : i_addr);
        cyc();
        push(exp_d, 32'h5000_0000 + 32'(r * 16 + g));
        smp();
        chk("tie_access_ready", 32'(mem_access), 32'h1);
      end
      cyc();
      mem_ready = 0;
      if (first_d) i_req = 0;
      else         d_req = 0;
      smp();
      chk("tie_back_idle", 32'(mem_access), 32'h0);
    end

    // Data-path latching, remap and stability under moving inputs.
    for (int v = 0; v < 6; v++) begin
      cyc();
      d_req = 1; d_write = vecs[v].write; d_size = vecs[v].size; d_sel = vecs[v].sel;
      d_addr = vecs[v].addr; d_wdata = vecs[v].wdata;
      smp();
      cyc();
      smp();
      chk("v_mem_a", mem_a, vecs[v].exp_a);
      chk("v_write", 32'(mem_write), 32'(vecs[v].write));
      chk("v_size", 32'(mem_size), 32'(vecs[v].size));
      chk("v_sel", 32'(mem_sel), 32'(vecs[v].sel));
      chk("v_st_data", mem_st_data, vecs[v].wdata);
      chk("v_stall_mem", 32'(stallreq_mem), 32'h1);
      cyc();
      d_addr = ~vecs[v].addr; d_wdata = ~vecs[v].wdata; d_sel = ~vecs[v].sel;
      smp();
      chk("v_mem_a_stable", mem_a, vecs[v].exp_a);
      chk("v_sel_stable", 32'(mem_sel), 32'(vecs[v].sel));
      chk("v_st_data_stable", mem_st_data, vecs[v].wdata);
      cyc();
      push(1'b1, vecs[v].wdata ^ 32'h5a5a5a5a);
      smp();
      chk("v_stall_mem_ready", 32'(stallreq_mem), 32'h0);
      cyc();
      mem_ready = 0; d_req = 0;
      smp();
      chk("v_back_idle", 32'(mem_access), 32'h0);
    end

    // Flush in the second DATA cycle, coinciding with mem_ready; pending fetch follows.
    cyc();
    d_req = 1; d_write = 0; d_size = 2'b10; d_sel = 4'b1111; d_addr = 32'h00001000;
    smp();
    cyc();
    i_req = 1; i_addr = 32'hbfc00200;
    smp();
    chk("fl_data_granted", mem_a, 32'h00001000);
    chk("fl_no_flush_yet", 32'(mem_flush), 32'h0);
    cyc();
    flush = 1; mem_ready = 1; mem_data = 32'hdeadbeef;
    smp();
    chk("fl_mem_flush", 32'(mem_flush), 32'h1);
    chk("fl_no_d_ready", 32'(d_ready), 32'h0);
    chk("fl_stall_mem", 32'(stallreq_mem), 32'h0);
    cyc();
    flush = 0; mem_ready = 0; d_req = 0;
    smp();
    chk("fl_idle", 32'(mem_access), 32'h0);
    chk("fl_flush_clear", 32'(mem_flush), 32'h0);
    cyc();
    smp();
    chk("fl_inst_access", 32'(mem_access), 32'h1);
    chk("fl_inst_addr", mem_a, 32'hbfc00200);
    cyc();
    push(1'b0, 32'h600dcafe);
    smp();
    chk("fl_i_ready", 32'(i_ready), 32'h1);
    cyc();
    mem_ready = 0; i_req = 0;
    smp();
    chk("fl_done_idle", 32'(mem_access), 32'h0);

    // Flush in IDLE blocks the data grant; mem_ready in IDLE is ignored.
    cyc();
    d_req = 1; flush = 1; d_addr = 32'h00002000; mem_ready = 1; mem_data = 32'h1;
    smp();
    chk("if_stall_mem_flush", 32'(stallreq_mem), 32'h0);
    cyc();
    mem_ready = 0;
    smp();
    chk("if_suppressed", 32'(mem_access), 32'h0);
    cyc();
    flush = 0;
    smp();
    chk("if_still_idle", 32'(mem_access), 32'h0);
    chk("if_stall_mem", 32'(stallreq_mem), 32'h1);
    cyc();
    smp();
    chk("if_granted", mem_a, 32'h00002000);
    cyc();
    push(1'b1, 32'h77665544);
    smp();
    cyc();
    mem_ready = 0; d_req = 0;

    // Asynchronous reset in the middle of a fetch.
    cyc();
    i_req = 1; i_addr = 32'hbfc00300;
    smp();
    cyc();
    smp();
    chk("ar_inst_access", 32'(mem_access), 32'h1);
    #2;
    aresetn = 0; mem_ready = 1; mem_data = 32'h12345678;
    #1;
    chk("ar_access", 32'(mem_access), 32'h0);
    chk("ar_mem_a", mem_a, 32'h0);
    chk("ar_attrs", {mem_write, mem_size, mem_sel}, 32'h0);
    chk("ar_i_ready", 32'(i_ready), 32'h0);
    chk("ar_i_rdata", i_rdata, 32'h0);
    cyc();
    mem_ready = 0; aresetn = 1;
    smp();
    chk("ar_idle_after", 32'(mem_access), 32'h0);
    cyc();
    smp();
    chk("ar_regrant", mem_a, 32'hbfc00300);
    cyc();
    push(1'b0, 32'h13572468);
    smp();
    chk("ar_i_ready_after", 32'(i_ready), 32'h1);
    cyc();
    mem_ready = 0; i_req = 0;
    smp();
    chk("ar_done_idle", 32'(mem_access), 32'h0);

    cyc();
    smp();
    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
